o_ddr_serializer: RTL

Parametrised output serializer that extends the single-pair DDR output cell to full parallel words. It accepts a WIDTH-bit word through a valid/ready handshake, double-buffers it, and shifts it out LSB-first on one pin at two bits per clock (DDR) or one bit per clock (SDR). It supports gapless back-to-back streaming, a programmable idle level and underrun reporting. It sits between fabric-side word producers and the I/O pad on the same clock domain.

---
 rtl/o_ddr_serializer_pkg.sv | 23 ++
 rtl/o_ddr_out_stage.sv | 37 +++
 rtl/o_ddr_serializer.sv | 99 +++++++++
 3 files changed

// File: rtl/o_ddr_serializer_pkg.sv
// Sizing helpers shared by the word-to-pin serializer and its output stage.
// Range limits here back the elaboration-time width check in the top level.
package o_ddr_serializer_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  // Bit order inside a pair: [0] drives the high phase, [1] the low phase.
  typedef logic [1:0] pair_t;

  function automatic int beats(input int width, input int ddr);
    return (ddr != 0) ? width / 2 : width;
  endfunction

  function automatic int cnt_w(input int n_beats);
    return (n_beats > 2) ? $clog2(n_beats) : 1;
  endfunction

  function automatic bit width_ok(input int width);
    return (width >= WIDTH_MIN) && (width <= WIDTH_MAX) && ((width % 2) == 0);
  endfunction

endpackage

// File: rtl/o_ddr_out_stage.sv
// Generalised DDR output cell: a posedge pair register, a negedge register
// for the low-phase bit and a clock-steered mux onto the pin.
module o_ddr_out_stage
  import o_ddr_serializer_pkg::*;
#(
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  pair_t pair_next,
  output logic  q
);

  pair_t pair;
  logic  neg_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair <= {IDLE_VAL, IDLE_VAL};
    end else if (en) begin
      pair <= pair_next;
    end
  end

  // Retiming the low-phase bit onto the falling edge keeps the mux glitch-free.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_bit <= IDLE_VAL;
    end else if (en) begin
      neg_bit <= pair[1];
    end
  end

  assign q = clk ? pair[0] : neg_bit;

endmodule

// File: rtl/o_ddr_serializer.sv
// Parallel word to single-pin serializer with a skid word, LSB-first shifting
// at one or two bits per clock, gapless back-to-back streaming and underrun flag.
module o_ddr_serializer
  import o_ddr_serializer_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter int   DDR      = 1,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic             C,
  input  logic             R,
  input  logic             E,
  input  logic [WIDTH-1:0] D,
  input  logic             LOAD,
  output logic             READY,
  output logic             Q,
  output logic             BUSY,
  output logic             UNDERRUN
);

  localparam bit WIDTH_OK = width_ok(WIDTH);
  localparam int BPB      = (DDR != 0) ? 2 : 1;
  localparam int BEATS    = beats(WIDTH, DDR);
  localparam int CW       = cnt_w(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  if (!WIDTH_OK) begin : g_width_check
    $error("o_ddr_serializer: WIDTH must be even and within 2..32");
  end

  logic [WIDTH-1:0] hold;
  logic             hold_v;
  logic [WIDTH-1:0] sr;
  logic             sr_v;
  logic [CW-1:0]    cnt;
  logic             underrun_q;
  logic             last_beat;
  logic             xfer;
  logic             accept;
  pair_t            pair_next;

  assign last_beat = sr_v & (cnt == LAST);
  // The skid word moves into the shifter on the same edge as the old word's
  // final beat, which is what makes streaming gapless.
  assign xfer      = hold_v & (~sr_v | last_beat);
  assign READY     = R & E & (~hold_v | xfer);
  assign accept    = LOAD & READY;
  assign BUSY      = hold_v | sr_v;
  assign UNDERRUN  = underrun_q;

  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      hold       <= '0;
      hold_v     <= 1'b0;
      sr         <= '0;
      sr_v       <= 1'b0;
      cnt        <= '0;
      underrun_q <= 1'b0;
    end else if (E) begin
      if (sr_v) begin
        sr  <= sr >> BPB;
        cnt <= last_beat ? '0 : cnt + 1'b1;
      end
      underrun_q <= last_beat & ~hold_v;
      if (last_beat & ~hold_v) begin
        sr_v <= 1'b0;
      end
      if (xfer) begin
        sr     <= hold;
        sr_v   <= 1'b1;
        cnt    <= '0;
        hold_v <= 1'b0;
      end
      // A new accept must win over the clear from the transfer above.
      if (accept) begin
        hold   <= D;
        hold_v <= 1'b1;
      end
    end
  end

  always_comb begin
    pair_next = {IDLE_VAL, IDLE_VAL};
    if (sr_v) begin
      pair_next = (DDR != 0) ? sr[1:0] : {sr[0], sr[0]};
    end
  end

  o_ddr_out_stage #(
    .IDLE_VAL (IDLE_VAL)
  ) u_out_stage (
    .clk       (C),
    .rst_n     (R),
    .en        (E),
    .pair_next (pair_next),
    .q         (Q)
  );

endmodule
